// File: rtl/ppi_lane_distributor.sv
// Spreads a packet byte stream across up to four PPI data lanes, preceded by a
// sync word and followed by a one-cycle end-of-transmission gap.
module ppi_lane_distributor #(
  parameter int unsigned       NUM_LANES = 4,
  parameter int unsigned       DATA_W    = 8,
  parameter logic [DATA_W-1:0] SYNC_BYTE = DATA_W'(8'hB8)
) (
  input  logic                        ppi_clk,
  input  logic                        ppi_rst,
  input  logic [2:0]                  cfg_active_lanes,
  input  logic [DATA_W-1:0]           s_data,
  input  logic                        s_valid,
  input  logic                        s_last,
  output logic                        s_ready,
  output logic [NUM_LANES*DATA_W-1:0] ppi_data,
  output logic [NUM_LANES-1:0]        ppi_lane_en,
  output logic                        busy,
  output logic                        err_cfg
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {IDLE, SYNC, DATA, EOT} state_t;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              lanes_q, lanes_d;
  logic [CNT_W-1:0]              fill_q, fill_d;
  logic [DATA_W-1:0]             stage_q [NUM_LANES];
  logic [DATA_W-1:0]             stage_d [NUM_LANES];
  logic [NUM_LANES*DATA_W-1:0]   data_d;
  logic [NUM_LANES-1:0]          en_d;
  logic                          ready_d, busy_d, err_d;

  // Next-state, staging and registered-output computation.
  always_comb begin
    state_d = state_q;
    lanes_d = lanes_q;
    fill_d  = fill_q;
    stage_d = stage_q;
    data_d  = ppi_data;
    en_d    = '0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        fill_d = '0;
        if (s_valid) begin
          state_d = SYNC;
          if (cfg_active_lanes == '0 || cfg_active_lanes > CNT_W'(NUM_LANES)) begin
            lanes_d = CNT_W'(NUM_LANES);
            err_d   = 1'b1;
          end else begin
            lanes_d = cfg_active_lanes;
          end
        end
      end
      SYNC: begin
        state_d = DATA;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
          if (CNT_W'(i) < lanes_q) begin
            data_d[i*DATA_W +: DATA_W] = SYNC_BYTE;
            en_d[i]                    = 1'b1;
          end
        end
      end
      DATA: begin
        if (s_valid && s_ready) begin
          for (int i = 0; i < int'(NUM_LANES); i++) begin
            if (CNT_W'(i) == fill_q) stage_d[i] = s_data;
          end
          // A word goes out once the last active slot fills or the packet ends.
          if (fill_q == lanes_q - CNT_W'(1) || s_last) begin
            for (int i = 0; i < int'(NUM_LANES); i++) begin
              data_d[i*DATA_W +: DATA_W] = stage_d[i];
              en_d[i]                    = (CNT_W'(i) <= fill_q);
            end
            fill_d = '0;
          end else begin
            fill_d = fill_q + CNT_W'(1);
          end
          if (s_last) state_d = EOT;
        end
      end
      EOT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == DATA);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge ppi_clk) begin
    if (ppi_rst) begin
      state_q     <= IDLE;
      lanes_q     <= CNT_W'(NUM_LANES);
      fill_q      <= '0;
      for (int i = 0; i < int'(NUM_LANES); i++) stage_q[i] <= '0;
      s_ready     <= 1'b0;
      ppi_data    <= '0;
      ppi_lane_en <= '0;
      busy        <= 1'b0;
      err_cfg     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lanes_q     <= lanes_d;
      fill_q      <= fill_d;
      stage_q     <= stage_d;
      s_ready     <= ready_d;
      ppi_data    <= data_d;
      ppi_lane_en <= en_d;
      busy        <= busy_d;
      err_cfg     <= err_d;
    end
  end

endmodule

// File: tb/tb_ppi_lane_distributor.sv
// Randomized packet bench: expected lane words are derived per packet from the
// byte list and lane count, then matched against the observed lane activity.
module tb_ppi_lane_distributor;

  logic        ppi_clk = 1'b0;
  logic        ppi_rst;
  logic [2:0]  cfg_active_lanes;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [31:0] ppi_data;
  logic [3:0]  ppi_lane_en;
  logic        busy;
  logic        err_cfg;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;
  logic last_acc;
  int err_seen;
  logic [3:0]  obs_en[$];
  logic [31:0] obs_data[$];
  int          obs_edge[$];

  ppi_lane_distributor dut (
    .ppi_clk(ppi_clk), .ppi_rst(ppi_rst), .cfg_active_lanes(cfg_active_lanes),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .ppi_data(ppi_data), .ppi_lane_en(ppi_lane_en), .busy(busy), .err_cfg(err_cfg)
  );

  always #5 ppi_clk = ~ppi_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] byte_mask(input logic [3:0] en);
    logic [31:0] m = '0;
    for (int i = 0; i < 4; i++) if (en[i]) m[i*8 +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [3:0] low_mask(input int n);
    return 4'((1 << n) - 1);
  endfunction

  // One clock: note whether the coming edge accepts a byte, then sample at negedge.
  task automatic tick();
    logic acc;
    acc = s_valid && s_ready && !ppi_rst;
    @(posedge ppi_clk);
    edge_n++;
    last_acc = acc;
    @(negedge ppi_clk);
    if (ppi_lane_en != 4'b0) begin
      obs_en.push_back(ppi_lane_en);
      obs_data.push_back(ppi_data & byte_mask(ppi_lane_en));
      obs_edge.push_back(edge_n);
    end
    if (err_cfg) err_seen++;
  endtask

  task automatic send_packet(input logic [2:0] c, input int n, input int gap);
    int lanes, k, start, budget, cnt, xe;
    logic illegal;
    logic [7:0]  b[$];
    int          acc_edge[$];
    logic [31:0] ed[$];
    logic [3:0]  ee[$];
    int          eidx[$];
    logic [31:0] d;
    illegal = (c == 3'd0 || c > 3'd4);
    lanes   = illegal ? 4 : int'(c);
    for (int i = 0; i < n; i++) b.push_back(8'($urandom));
    // Expected words: sync, then the byte list cut into chunks of `lanes`.
    d = '0;
    for (int j = 0; j < lanes; j++) d[j*8 +: 8] = 8'hB8;
    ed.push_back(d); ee.push_back(low_mask(lanes)); eidx.push_back(-1);
    for (int k0 = 0; k0 < n; k0 += lanes) begin
      cnt = (n - k0 < lanes) ? n - k0 : lanes;
      d = '0;
      for (int j = 0; j < cnt; j++) d[j*8 +: 8] = b[k0+j];
      ed.push_back(d); ee.push_back(low_mask(cnt)); eidx.push_back(k0 + cnt - 1);
    end
    obs_en.delete(); obs_data.delete(); obs_edge.delete();
    err_seen = 0;

    check("idle_ready", 32'(s_ready), 32'd0);
    cfg_active_lanes = c; s_valid = 1'b1; s_data = b[0]; s_last = (n == 1);
    tick();
    start = edge_n;
    check("sync_ready", 32'(s_ready), 32'd0);
    check("sync_busy", 32'(busy), 32'd1);
    cfg_active_lanes = 3'($urandom);
    s_valid = 1'($urandom);
    tick();
    k = 0; budget = 0;
    while (k < n) begin
      check("data_ready", 32'(s_ready), 32'd1);
      s_valid = ($urandom_range(99) >= gap);
      s_data  = b[k];
      s_last  = (k == n - 1);
      cfg_active_lanes = 3'($urandom);
      tick();
      if (last_acc) begin
        acc_edge.push_back(edge_n);
        k++;
      end
      budget++;
      if (budget > 2000) begin
        check("accept_timeout", 32'(k), 32'(n));
        break;
      end
    end
    check("eot_ready", 32'(s_ready), 32'd0);
    check("eot_busy", 32'(busy), 32'd1);
    s_valid = 1'b0; s_last = 1'b0;
    tick();
    check("gap_en", 32'(ppi_lane_en), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_ready2", 32'(s_ready), 32'd0);

    check("word_count", 32'(obs_en.size()), 32'(ee.size()));
    for (int i = 0; i < ee.size() && i < obs_en.size(); i++) begin
      check("word_en", 32'(obs_en[i]), 32'(ee[i]));
      check("word_data", obs_data[i], ed[i]);
      if (eidx[i] < 0) xe = start + 1;
      else if (eidx[i] < acc_edge.size()) xe = acc_edge[eidx[i]];
      else xe = -1;
      check("word_edge", 32'(obs_edge[i]), 32'(xe));
    end
    check("err_cfg_pulses", 32'(err_seen), 32'(illegal));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(s_ready), 32'd0);
    check({tag, "_data"}, ppi_data, 32'd0);
    check({tag, "_en"}, 32'(ppi_lane_en), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err"}, 32'(err_cfg), 32'd0);
  endtask

  initial begin
    ppi_rst = 1'b1; cfg_active_lanes = 3'd4; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
    tick(); tick();
    check_all_zero("reset");
    ppi_rst = 1'b0;
    tick();

    send_packet(3'd4, 8, 0);
    send_packet(3'd4, 6, 0);
    send_packet(3'd2, 3, 50);
    send_packet(3'd0, 5, 0);
    send_packet(3'd7, 6, 20);
    send_packet(3'd1, 2, 0);
    send_packet(3'd1, 2, 0);
    send_packet(3'd3, 7, 30);

    // Reset in the middle of a 4-lane packet after two accepted bytes.
    obs_en.delete(); obs_data.delete(); obs_edge.delete();
    cfg_active_lanes = 3'd4; s_valid = 1'b1; s_data = 8'h21; s_last = 1'b0;
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      s_data = 8'(8'h22 + i);
      tick();
    end
    ppi_rst = 1'b1; s_valid = 1'b0;
    tick();
    check_all_zero("midrst");
    check("midrst_words", 32'(obs_en.size()), 32'd1);
    ppi_rst = 1'b0;
    tick();
    send_packet(3'd4, 4, 0);

    for (int p = 0; p < 12; p++)
      send_packet(3'($urandom), int'($urandom_range(12, 1)), int'($urandom_range(50, 0)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
